// File: rtl/str_to_num_pkg.sv
// Shared state encoding and ASCII constants for the
// str_to_num / str_sender block family.
package str_to_num_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ZERO,
      DEC,
      HEX_PFX,
      HEX,
      EMIT
   } state_t;

   localparam logic [7:0] CH_0  = 8'h30;
   localparam logic [7:0] CH_9  = 8'h39;
   localparam logic [7:0] CH_UA = 8'h41;
   localparam logic [7:0] CH_UF = 8'h46;
   localparam logic [7:0] CH_LA = 8'h61;
   localparam logic [7:0] CH_LF = 8'h66;
   localparam logic [7:0] CH_LX = 8'h78;
   localparam logic [7:0] CH_UX = 8'h58;

endpackage

// File: rtl/str_to_num_ascii_digit.sv
// Combinational ASCII classifier: decimal/hex digit flags
// and the digit's numeric value.
module ascii_digit
   import str_to_num_pkg::*;
(
   input  logic [7:0] ch,
   output logic       is_dec,
   output logic       is_hex,
   output logic [3:0] value
);

   logic is_up;
   logic is_lo;

   always_comb begin
      is_dec = (ch >= CH_0) && (ch <= CH_9);
      is_up  = (ch >= CH_UA) && (ch <= CH_UF);
      is_lo  = (ch >= CH_LA) && (ch <= CH_LF);
      is_hex = is_dec || is_up || is_lo;
      value  = '0;
      unique case (1'b1)
         is_dec:         value = ch[3:0];
         is_up, is_lo:   value = ch[3:0] + 4'd9;
         default:        value = '0;
      endcase
   end

endmodule

// File: rtl/str_to_num.sv
// ASCII character stream to unsigned number parser with
// decimal and 0x-prefixed hex support and sticky overflow.
module str_to_num
   import str_to_num_pkg::*;
#(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [7:0]   s_dtm,
   input  logic         s_vld,
   output logic         s_rdy,
   output logic [W-1:0] m_dtm,
   output logic         m_hex,
   output logic         m_ovf,
   output logic         m_vld,
   input  logic         m_rdy
);

   state_t         st, st_nxt;
   logic [W-1:0]   acc, acc_nxt;
   logic           ovf, ovf_nxt;
   logic           hex, hex_nxt;
   logic           is_dec, is_hex;
   logic [3:0]     dv;
   logic [W+3:0]   dec_step, hex_step;
   logic           s_fire, m_fire, is_x;

   ascii_digit u_dig (
      .ch     (s_dtm),
      .is_dec (is_dec),
      .is_hex (is_hex),
      .value  (dv)
   );

   // Four guard bits catch any carry out of the low W bits.
   assign dec_step = {4'b0, acc} * (W+4)'(10) + (W+4)'(dv);
   assign hex_step = {acc, dv};
   assign s_fire   = s_vld && s_rdy;
   assign m_fire   = m_vld && m_rdy;
   assign is_x     = (s_dtm == CH_LX) || (s_dtm == CH_UX);

   always_ff @(posedge clk) begin
      if (rst) begin
         st  <= IDLE;
         acc <= '0;
         ovf <= 1'b0;
         hex <= 1'b0;
      end else begin
         st  <= st_nxt;
         acc <= acc_nxt;
         ovf <= ovf_nxt;
         hex <= hex_nxt;
      end
   end

   always_comb begin
      st_nxt  = st;
      acc_nxt = acc;
      ovf_nxt = ovf;
      hex_nxt = hex;
      unique case (st)
         IDLE: if (s_fire && is_dec) begin
            acc_nxt = W'(dv);
            st_nxt  = (dv == 4'd0) ? ZERO : DEC;
         end
         ZERO: if (s_fire) begin
            unique case (1'b1)
               is_x: begin
                  st_nxt  = HEX_PFX;
                  hex_nxt = 1'b1;
               end
               is_dec: begin
                  st_nxt  = DEC;
                  acc_nxt = W'(dv);
               end
               default: st_nxt = EMIT;
            endcase
         end
         HEX_PFX: if (s_fire) begin
            if (is_hex) begin
               st_nxt  = HEX;
               acc_nxt = W'(dv);
            end else begin
               st_nxt = EMIT;
            end
         end
         DEC: if (s_fire) begin
            if (is_dec) begin
               acc_nxt = dec_step[W-1:0];
               ovf_nxt = ovf || (|dec_step[W+3:W]);
            end else begin
               st_nxt = EMIT;
            end
         end
         HEX: if (s_fire) begin
            if (is_hex) begin
               acc_nxt = hex_step[W-1:0];
               ovf_nxt = ovf || (|hex_step[W+3:W]);
            end else begin
               st_nxt = EMIT;
            end
         end
         EMIT: if (m_fire) begin
            st_nxt  = IDLE;
            acc_nxt = '0;
            ovf_nxt = 1'b0;
            hex_nxt = 1'b0;
         end
         default: st_nxt = IDLE;
      endcase
   end

   always_comb begin
      m_vld = (st == EMIT);
      s_rdy = !m_vld;
      m_dtm = acc;
      m_hex = hex;
      m_ovf = ovf;
   end

endmodule

// File: tb/tb_str_to_num.sv
// Directed scoreboard bench for str_to_num (W=32).
module tb_str_to_num;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  s_dtm;
   logic        s_vld;
   logic        s_rdy;
   logic [31:0] m_dtm;
   logic        m_hex;
   logic        m_ovf;
   logic        m_vld;
   logic        m_rdy;

   typedef struct {
      logic [31:0] dtm;
      logic        hex;
      logic        ovf;
   } exp_t;

   exp_t sbq[$];
   exp_t mon_e;
   int   n_cmp = 0;
   int   n_bad = 0;
   bit   rnd = 1'b0;
   bit   done;

   localparam string S1 = "19/08/2005: 0x5F3759DF = 1597463007\n";

   str_to_num #(.W(32)) dut (
      .clk   (clk),
      .rst   (rst),
      .s_dtm (s_dtm),
      .s_vld (s_vld),
      .s_rdy (s_rdy),
      .m_dtm (m_dtm),
      .m_hex (m_hex),
      .m_ovf (m_ovf),
      .m_vld (m_vld),
      .m_rdy (m_rdy)
   );

   always #5 clk = ~clk;

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   always @(negedge clk) begin
      if (!rst && m_vld && m_rdy) begin
         n_cmp++;
         if (sbq.size() == 0) begin
            n_bad++;
            $error("FAIL sb_extra: got %0h/%0b/%0b expected none",
                   m_dtm, m_hex, m_ovf);
         end else begin
            mon_e = sbq.pop_front();
            assert ({m_dtm, m_hex, m_ovf} ===
                    {mon_e.dtm, mon_e.hex, mon_e.ovf})
            else begin
               n_bad++;
               $error("FAIL sb_num: got %0h/%0b/%0b expected %0h/%0b/%0b",
                      m_dtm, m_hex, m_ovf,
                      mon_e.dtm, mon_e.hex, mon_e.ovf);
            end
         end
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rnd) m_rdy = 1'($urandom_range(0, 1));
      end
   end

   task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_bad++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push(logic [31:0] d, logic h, logic o);
      exp_t e;
      e.dtm = d;
      e.hex = h;
      e.ovf = o;
      sbq.push_back(e);
   endtask

   task automatic send_char(logic [7:0] c, bit gaps);
      bit ok;
      ok = 1'b0;
      if (gaps) begin
         repeat ($urandom_range(0, 3)) begin
            @(posedge clk);
            #1;
         end
      end
      s_dtm = c;
      s_vld = 1'b1;
      for (int i = 0; i < 300 && !ok; i++) begin
         @(negedge clk);
         if (s_rdy) ok = 1'b1;
         @(posedge clk);
         #1;
      end
      s_vld = 1'b0;
      if (!ok) chk("send_timeout", 64'(ok), 64'd1);
   endtask

   task automatic send_str(string s, bit gaps);
      for (int i = 0; i < s.len(); i++) send_char(s[i], gaps);
   endtask

   task automatic drain();
      for (int i = 0; i < 500 && sbq.size() != 0; i++) begin
         @(posedge clk);
         #1;
      end
      chk("drain", 64'(sbq.size()), 64'd0);
   endtask

   task automatic push_s1();
      push(32'd19, 1'b0, 1'b0);
      push(32'd8, 1'b0, 1'b0);
      push(32'd2005, 1'b0, 1'b0);
      push(32'h5F3759DF, 1'b1, 1'b0);
      push(32'd1597463007, 1'b0, 1'b0);
   endtask

   initial begin
      rst   = 1'b1;
      s_vld = 1'b0;
      s_dtm = 8'h00;
      m_rdy = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_m_vld", 64'(m_vld), 64'd0);
      chk("rst_s_rdy", 64'(s_rdy), 64'd1);
      chk("rst_m_dtm", 64'(m_dtm), 64'd0);
      chk("rst_m_hex", 64'(m_hex), 64'd0);
      chk("rst_m_ovf", 64'(m_ovf), 64'd0);
      rst = 1'b0;

      // Mixed decimal/hex stream at full throughput.
      push_s1();
      send_str(S1, 1'b0);
      drain();

      push(32'd0, 1'b0, 1'b0);
      push(32'd0, 1'b1, 1'b0);
      send_str("0 0x;", 1'b0);
      drain();

      push(32'd0, 1'b0, 1'b1);
      push(32'hFFFFFFFF, 1'b0, 1'b0);
      push(32'h23456789, 1'b1, 1'b1);
      send_str("4294967296,4294967295,0x123456789 ", 1'b0);
      drain();

      push(32'd8, 1'b0, 1'b0);
      push(32'd1, 1'b1, 1'b0);
      push(32'hAB, 1'b1, 1'b0);
      push(32'd0, 1'b1, 1'b0);
      send_str("008,0x0001 0XaB;0xg", 1'b0);
      drain();

      // High-bit character terminates and is not read as '1'.
      push(32'd5, 1'b0, 1'b0);
      push(32'd7, 1'b0, 1'b0);
      send_str("5", 1'b0);
      send_char(8'hB1, 1'b0);
      send_str("7 ", 1'b0);
      drain();

      // Backpressure holds the number and stalls input.
      m_rdy = 1'b0;
      push(32'd12, 1'b0, 1'b0);
      push(32'd34, 1'b0, 1'b0);
      send_str("12,", 1'b0);
      done = 1'b0;
      fork
         begin
            send_str("34,", 1'b0);
            done = 1'b1;
         end
      join_none
      repeat (10) begin
         @(negedge clk);
         chk("bp_s_rdy", 64'(s_rdy), 64'd0);
         chk("bp_m_vld", 64'(m_vld), 64'd1);
         chk("bp_m_dtm", 64'(m_dtm), 64'd12);
      end
      @(posedge clk);
      #1;
      m_rdy = 1'b1;
      for (int i = 0; i < 300 && !done; i++) @(posedge clk);
      chk("bp_done", 64'(done), 64'd1);
      #1;
      drain();

      // Reset drops a partial number.
      send_str("12", 1'b0);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      push(32'd7, 1'b0, 1'b0);
      send_str("7 ", 1'b0);
      drain();

      // Reset drops a pending number.
      m_rdy = 1'b0;
      send_str("5,", 1'b0);
      @(negedge clk);
      chk("emit_m_vld", 64'(m_vld), 64'd1);
      chk("emit_m_dtm", 64'(m_dtm), 64'd5);
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      chk("rst_emit_m_vld", 64'(m_vld), 64'd0);
      chk("rst_emit_s_rdy", 64'(s_rdy), 64'd1);
      chk("rst_emit_m_dtm", 64'(m_dtm), 64'd0);
      m_rdy = 1'b1;

      // Same stream with random gaps on both sides.
      rnd = 1'b1;
      push_s1();
      send_str(S1, 1'b1);
      drain();
      rnd = 1'b0;
      @(posedge clk);
      #2;
      m_rdy = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      chk("sb_empty", 64'(sbq.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
